// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-way traffic light sequencer with pedestrian walk insertion
// Optional green-end warning flash is enabled by defining TRAFFIC_FLASH_WARN_EN.
module intersection_scheduler #(
    parameter int LONG_GREEN   = 350,
    parameter int SHORT_GREEN  = 200,
    parameter int AMBER_TICKS  = 30,
    parameter int ALLRED_TICKS = 20,
    parameter int WALK_TICKS   = 100
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       mode,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_amber,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_amber,
    output logic       ew_green,
    output logic       walk,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        ALLRED_A = 3'd0,
        NS_GREEN = 3'd1,
        NS_AMBER = 3'd2,
        ALLRED_B = 3'd3,
        EW_GREEN = 3'd4,
        EW_AMBER = 3'd5,
        PED_WALK = 3'd6
    } state_t;

    // counter reload value: duration-1, with a zero duration treated as one cycle
    function automatic logic [9:0] ld(input int t);
        return (t < 1) ? 10'd0 : 10'(t - 1);
    endfunction

    localparam logic [9:0] L_LONG   = ld(LONG_GREEN);
    localparam logic [9:0] L_SHORT  = ld(SHORT_GREEN);
    localparam logic [9:0] L_AMBER  = ld(AMBER_TICKS);
    localparam logic [9:0] L_ALLRED = ld(ALLRED_TICKS);
    localparam logic [9:0] L_WALK   = ld(WALK_TICKS);

    state_t     state, nstate;
    logic [9:0] cnt, ncnt;
    logic       pend, dir, ndir, enter_walk, warn;

    // next phase, next-direction memory and counter reload on phase entry
    always_comb begin
        nstate = state;
        ndir   = dir;
        if (cnt == 10'd0) begin
            case (state)
                ALLRED_A: begin nstate = pend ? PED_WALK : NS_GREEN; ndir = 1'b0; end
                NS_GREEN: nstate = NS_AMBER;
                NS_AMBER: nstate = ALLRED_B;
                ALLRED_B: begin nstate = pend ? PED_WALK : EW_GREEN; ndir = 1'b1; end
                EW_GREEN: nstate = EW_AMBER;
                EW_AMBER: nstate = ALLRED_A;
                PED_WALK: nstate = dir ? EW_GREEN : NS_GREEN;
                default:  nstate = ALLRED_A;
            endcase
        end
        ncnt = (cnt != 10'd0) ? cnt - 10'd1 :
               (nstate == NS_GREEN || nstate == EW_GREEN) ? (mode ? L_SHORT : L_LONG) :
               (nstate == NS_AMBER || nstate == EW_AMBER) ? L_AMBER :
               (nstate == PED_WALK) ? L_WALK : L_ALLRED;
        enter_walk = (cnt == 10'd0) && (nstate == PED_WALK);
    end

`ifdef TRAFFIC_FLASH_WARN_EN
    // final four green cycles (counter 3,2,1,0) blink 0,1,0,1
    assign warn = (ncnt > 10'd3) || !ncnt[0];
`else
    assign warn = 1'b1;
`endif

    // phase/counter state plus lamps registered from the upcoming phase
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ALLRED_A;
            cnt      <= L_ALLRED;
            pend     <= 1'b0;
            dir      <= 1'b0;
            ns_red   <= 1'b1;
            ns_amber <= 1'b0;
            ns_green <= 1'b0;
            ew_red   <= 1'b1;
            ew_amber <= 1'b0;
            ew_green <= 1'b0;
            walk     <= 1'b0;
        end else begin
            state    <= nstate;
            cnt      <= ncnt;
            dir      <= ndir;
            pend     <= ped_req | (pend & ~enter_walk);
            ns_red   <= !(nstate == NS_GREEN || nstate == NS_AMBER);
            ns_amber <= nstate == NS_AMBER;
            ns_green <= (nstate == NS_GREEN) && warn;
            ew_red   <= !(nstate == EW_GREEN || nstate == EW_AMBER);
            ew_amber <= nstate == EW_AMBER;
            ew_green <= (nstate == EW_GREEN) && warn;
            walk     <= nstate == PED_WALK;
        end
    end

    assign phase = state;
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: directed checks of phase sequencing, timing, pedestrian walk and reset
module tb_intersection_scheduler;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode = 1'b0;
    logic       ped_req = 1'b0;
    logic       ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk;
    logic [2:0] phase;
    logic [6:0] lamps;
    int         total = 0;
    int         bad = 0;

    intersection_scheduler #(
        .LONG_GREEN(10), .SHORT_GREEN(6), .AMBER_TICKS(3), .ALLRED_TICKS(2), .WALK_TICKS(4)
    ) dut (
        .clock(clock), .reset_n(reset_n), .mode(mode), .ped_req(ped_req),
        .ns_red(ns_red), .ns_amber(ns_amber), .ns_green(ns_green),
        .ew_red(ew_red), .ew_amber(ew_amber), .ew_green(ew_green),
        .walk(walk), .phase(phase)
    );

    always #5 clock = ~clock;
    assign lamps = {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green, walk};

    // expected lamps {ns r,a,g, ew r,a,g, walk} for a phase with c cycles left after this one
    function automatic logic [6:0] exp_lamps(input int ph, input int c);
        logic g;
`ifdef TRAFFIC_FLASH_WARN_EN
        g = (c == 3 || c == 1) ? 1'b0 : 1'b1;
`else
        g = (c >= 0);
`endif
        case (ph)
            1: exp_lamps = {2'b00, g, 4'b1000};
            2: exp_lamps = 7'b0101000;
            4: exp_lamps = {4'b1000, 1'b0, g, 1'b0};
            5: exp_lamps = 7'b1000100;
            6: exp_lamps = 7'b1001001;
            default: exp_lamps = 7'b1001000;
        endcase
    endfunction

    // length of the phase currently showing, leaving us on the first sample of the next one
    task automatic measure(output logic [2:0] ph, output int len);
        ph = phase;
        len = 0;
        while (phase === ph && len < 2000) begin
            len++;
            @(negedge clock);
        end
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if (phase !== 3'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
        total++;
        if (lamps !== 7'b1001000) begin bad++; $display("FAIL reset_lamps got=%b want=1001000", lamps); end
    endtask

    task automatic test_sequence();
        int ph[7] = '{0, 1, 2, 3, 4, 5, 0};
        int ln[7] = '{2, 10, 3, 2, 10, 3, 2};
        release_reset();
        for (int s = 0; s < 7; s++) begin
            for (int k = 0; k < ln[s]; k++) begin
                total++;
                if (phase !== 3'(ph[s])) begin
                    bad++; $display("FAIL seq_phase seg=%0d cyc=%0d got=%0d want=%0d", s, k, phase, ph[s]);
                end
                total++;
                if (lamps !== exp_lamps(ph[s], ln[s] - 1 - k)) begin
                    bad++; $display("FAIL seq_lamps seg=%0d cyc=%0d got=%b want=%b", s, k, lamps, exp_lamps(ph[s], ln[s] - 1 - k));
                end
                @(negedge clock);
            end
        end
        total++;
        if (phase !== 3'd1) begin bad++; $display("FAIL seq_wrap got=%0d want=1", phase); end
    endtask

    task automatic test_mode();
        logic [2:0] p;
        int         n;
        int         ep[7] = '{1, 2, 3, 4, 5, 0, 1};
        int         el[7] = '{7, 3, 2, 6, 3, 2, 10};
        repeat (3) @(negedge clock);
        mode = 1'b1;
        for (int s = 0; s < 7; s++) begin
            measure(p, n);
            if (s == 3) mode = 1'b0;
            total++;
            if (p !== 3'(ep[s]) || n !== el[s]) begin
                bad++; $display("FAIL mode_seg%0d got=%0d/%0d want=%0d/%0d", s, p, n, ep[s], el[s]);
            end
        end
    endtask

    task automatic test_ped_pulse();
        logic [2:0] p;
        int         n;
        int         ep[3] = '{1, 2, 3};
        int         el[3] = '{8, 3, 2};
        int         fp[3] = '{4, 5, 0};
        int         fl[3] = '{10, 3, 2};
        for (int i = 0; i < 100 && phase !== 3'd1; i++) @(negedge clock);
        @(negedge clock);
        ped_req = 1'b1;
        @(negedge clock);
        ped_req = 1'b0;
        for (int s = 0; s < 3; s++) begin
            measure(p, n);
            total++;
            if (p !== 3'(ep[s]) || n !== el[s]) begin
                bad++; $display("FAIL ped_pre%0d got=%0d/%0d want=%0d/%0d", s, p, n, ep[s], el[s]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (phase !== 3'd6 || lamps !== 7'b1001001) begin
                bad++; $display("FAIL ped_walk cyc=%0d got=%0d/%b want=6/1001001", k, phase, lamps);
            end
            @(negedge clock);
        end
        for (int s = 0; s < 3; s++) begin
            measure(p, n);
            total++;
            if (p !== 3'(fp[s]) || n !== fl[s]) begin
                bad++; $display("FAIL ped_post%0d got=%0d/%0d want=%0d/%0d", s, p, n, fp[s], fl[s]);
            end
        end
        total++;
        if (phase !== 3'd1) begin bad++; $display("FAIL ped_no_repeat got=%0d want=1", phase); end
    endtask

    task automatic test_ped_entry();
        logic [2:0] p;
        int         n;
        int         ep[8] = '{6, 4, 5, 0, 6, 1, 2, 3};
        int         el[8] = '{4, 10, 3, 2, 4, 10, 3, 2};
        ped_req = 1'b1;
        for (int i = 0; i < 300 && phase !== 3'd6; i++) @(negedge clock);
        ped_req = 1'b0;
        for (int s = 0; s < 8; s++) begin
            measure(p, n);
            total++;
            if (p !== 3'(ep[s]) || n !== el[s]) begin
                bad++; $display("FAIL entry_seg%0d got=%0d/%0d want=%0d/%0d", s, p, n, ep[s], el[s]);
            end
        end
        total++;
        if (phase !== 3'd4) begin bad++; $display("FAIL entry_no_third got=%0d want=4", phase); end
    endtask

    task automatic test_reset_walk();
        logic [2:0] p;
        int         n;
        ped_req = 1'b1;
        @(negedge clock);
        ped_req = 1'b0;
        for (int i = 0; i < 300 && phase !== 3'd6; i++) @(negedge clock);
        total++;
        if (phase !== 3'd6) begin bad++; $display("FAIL rw_reach_walk got=%0d want=6", phase); end
        @(negedge clock);
        ped_req = 1'b1;
        @(negedge clock);
        ped_req = 1'b0;
        reset_n = 1'b0;
        #1;
        total++;
        if (phase !== 3'd0 || lamps !== 7'b1001000) begin
            bad++; $display("FAIL rw_async got=%0d/%b want=0/1001000", phase, lamps);
        end
        repeat (2) @(negedge clock);
        release_reset();
        measure(p, n);
        total++;
        if (p !== 3'd0 || n !== 2) begin bad++; $display("FAIL rw_allred got=%0d/%0d want=0/2", p, n); end
        total++;
        if (phase !== 3'd1) begin bad++; $display("FAIL rw_pend_cleared got=%0d want=1", phase); end
    endtask

    task automatic test_flash();
        logic e;
        for (int k = 0; k < 10; k++) begin
`ifdef TRAFFIC_FLASH_WARN_EN
            e = (k == 6 || k == 8) ? 1'b0 : 1'b1;
`else
            e = 1'b1;
`endif
            total++;
            if (ns_green !== e) begin bad++; $display("FAIL flash cyc=%0d got=%b want=%b", k, ns_green, e); end
            @(negedge clock);
        end
        total++;
        if (phase !== 3'd2) begin bad++; $display("FAIL flash_end got=%0d want=2", phase); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_mode();
        test_ped_pulse();
        test_ped_entry();
        test_reset_walk();
        test_flash();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 SHALL have parameter LONG_GREEN, default 350: green duration in clock cycles when mode=0.
REQ-002 SHALL have parameter SHORT_GREEN, default 200: green duration in clock cycles when mode=1.
REQ-003 SHALL have parameter AMBER_TICKS, default 30: amber duration in clock cycles.
REQ-004 SHALL have parameter ALLRED_TICKS, default 20: all-red clearance duration in clock cycles.
REQ-005 SHALL have parameter WALK_TICKS, default 100: pedestrian walk duration in clock cycles.
REQ-006 SHALL have port clock, input, 1: single rising-edge clock.
REQ-007 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port mode, input, 1: green-length select (0 = long, 1 = short).
REQ-009 SHALL have port ped_req, input, 1: pedestrian request, level- or pulse-driven, synchronous to clock.
REQ-010 SHALL have ports ns_red, ns_amber, ns_green, output, 1 each: north-south lamps.
REQ-011 SHALL have ports ew_red, ew_amber, ew_green, output, 1 each: east-west lamps.
REQ-012 SHALL have port walk, output, 1: pedestrian walk lamp.
REQ-013 SHALL have port phase, output, 3: current state code (ALLRED_A=0, NS_GREEN=1, NS_AMBER=2, ALLRED_B=3, EW_GREEN=4, EW_AMBER=5, PED_WALK=6).

Function
REQ-014 SHALL use a 10-bit down-counter; all tick parameters SHALL be 1..1023, with 0 treated as 1.
REQ-015 SHALL, on entry to a state, load the counter with duration-1 and leave the state in the cycle the counter equals 0, so each state lasts exactly its duration.
REQ-016 SHALL sequence ALLRED_A -> NS_GREEN -> NS_AMBER -> ALLRED_B -> EW_GREEN -> EW_AMBER -> ALLRED_A.
REQ-017 SHALL, at the end of ALLRED_A or ALLRED_B with ped_pending=1, enter PED_WALK instead, then continue to NS_GREEN or EW_GREEN respectively (a 1-bit next-direction register).
REQ-018 SHALL sample mode only in the cycle of green entry; mode changes during green SHALL NOT alter the current green length.
REQ-019 SHALL set ped_pending on any cycle with ped_req=1 and clear it in the cycle PED_WALK is entered; set SHALL win over a simultaneous clear.
REQ-020 SHALL, with ped_req held high, insert PED_WALK after every all-red phase.
REQ-021 SHALL drive lamps as registered outputs: red on for a direction in every state except its own green/amber; amber on only in its AMBER state; green on only in its GREEN state; walk=1 only in PED_WALK.
REQ-022 SHALL never assert green or amber on both directions at once, and SHALL never assert walk together with any green or amber.

Reset
REQ-023 SHALL, while reset_n=0, asynchronously force phase=ALLRED_A, ns_red=ew_red=1, all other lamps 0, ped_pending=0, next-direction=NS, counter=ALLRED_TICKS-1.
REQ-024 SHALL, on reset assertion mid-phase (including mid-walk), discard the phase and any pending request; after release, the first ALLRED_A SHALL last the full ALLRED_TICKS.

Configuration
REQ-025 SHALL compile green-end warning flash only when macro TRAFFIC_FLASH_WARN_EN is defined: the direction's green output during the final 4 green cycles (counter 3,2,1,0) SHALL be 0,1,0,1; both green values SHALL be >= 5.
REQ-026 SHALL, without TRAFFIC_FLASH_WARN_EN, hold green steady at 1 for the entire green phase.

Verification (bench parameters LONG_GREEN=10, SHORT_GREEN=6, AMBER_TICKS=3, ALLRED_TICKS=2, WALK_TICKS=4)
REQ-027 SHALL cover reset release with mode=0 and ped_req=0: phases 0,1,2,3,4,5,0 lasting 2,10,3,2,10,3,2 cycles, with lamps matching REQ-021.
REQ-028 SHALL cover a mode toggle 0->1 in mid NS green: NS green stays 10 cycles, and the next EW green lasts 6.
REQ-029 SHALL cover a 1-cycle ped_req during NS_GREEN: after ALLRED_B, walk=1 for 4 cycles, then EW_GREEN, and no further PED_WALK without a new request.
REQ-030 SHALL cover ped_req asserted in the PED_WALK entry cycle: pending remains set and a second PED_WALK follows the next all-red.
REQ-031 SHALL cover reset_n pulsed low in mid PED_WALK: outputs immediately at reset values, pending cleared, and the sequence restarts at ALLRED_A for 2 cycles.
REQ-032 SHALL cover TRAFFIC_FLASH_WARN_EN defined with mode=0: ns_green reads 1x6 then 0,1,0,1; with the macro undefined, ns_green reads 1x10.
